// File: rtl/systolic_array_controller.sv
// systolic_array_controller: sequences one weight-stationary systolic-array job (clear, load weights, stream, drain, done)
// Ports:
//   CLK, ASYNC_RST        clock (rising edge), asynchronous active-low reset
//   START, NUM_VECTORS    job request and vector count, accepted only in IDLE
//   STALL, ABORT          freeze sequencing / cancel current job (ABORT wins)
//   BUSY, DONE            job in flight / one-cycle completion pulse
//   PE_SYNC_RST, PE_LOAD  broadcast PE clear and weight-load strobes
//   W_ROW_ADDR            weight-buffer row being loaded
//   PE_EN, IN_VALID       broadcast PE enable; input buffer read valid
//   IN_ADDR               input-vector index
//   OUT_VALID, OUT_ADDR   bottom-row (column 0) result valid and its vector index
module systolic_array_controller #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int VEC_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     ASYNC_RST,
    input  logic                     START,
    input  logic [VEC_WIDTH-1:0]     NUM_VECTORS,
    input  logic                     STALL,
    input  logic                     ABORT,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     PE_SYNC_RST,
    output logic                     PE_LOAD,
    output logic [$clog2(ROWS)-1:0]  W_ROW_ADDR,
    output logic                     PE_EN,
    output logic                     IN_VALID,
    output logic [VEC_WIDTH-1:0]     IN_ADDR,
    output logic                     OUT_VALID,
    output logic [VEC_WIDTH-1:0]     OUT_ADDR
);
    localparam int RW = $clog2(ROWS);
    localparam int TW = VEC_WIDTH + 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [RW-1:0]        w_cnt;
    logic [VEC_WIDTH-1:0] n_reg;
    // t counts unstalled COMPUTE+DRAIN cycles; the extra bit keeps N+ROWS+COLS-2 from wrapping
    logic [TW-1:0]        t;
    logic [TW-1:0]        n_ext;
    logic                 go, streaming, out_win, accept;

    always_comb begin
        n_ext     = {1'b0, n_reg};
        go        = !STALL;
        accept    = START && (NUM_VECTORS != '0) && !ABORT;
        streaming = (state == S_COMPUTE) || (state == S_DRAIN);
        // bottom row sees vector k at t = k + ROWS
        out_win   = streaming && (t >= TW'(ROWS)) && (t <= n_ext + TW'(ROWS - 1));
        state_nxt = state;
        case (state)
            S_IDLE:    state_nxt = accept ? S_CLEAR : S_IDLE;
            S_CLEAR:   state_nxt = S_LOAD;
            S_LOAD:    state_nxt = (go && w_cnt == RW'(ROWS - 1)) ? S_COMPUTE : S_LOAD;
            S_COMPUTE: state_nxt = (go && t == n_ext - TW'(1)) ? S_DRAIN : S_COMPUTE;
            S_DRAIN:   state_nxt = (go && t == n_ext + TW'(ROWS + COLS - 2)) ? S_DONE : S_DRAIN;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (ABORT && state != S_IDLE)
            state_nxt = S_IDLE;
        BUSY        = state != S_IDLE;
        DONE        = state == S_DONE;
        PE_SYNC_RST = state == S_CLEAR;
        PE_LOAD     = (state == S_LOAD) && go;
        W_ROW_ADDR  = (state == S_LOAD) ? w_cnt : '0;
        PE_EN       = streaming && go;
        IN_VALID    = (state == S_COMPUTE) && go;
        IN_ADDR     = (state == S_COMPUTE) ? t[VEC_WIDTH-1:0] : '0;
        OUT_VALID   = out_win && go;
        OUT_ADDR    = out_win ? VEC_WIDTH'(t - TW'(ROWS)) : '0;
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state <= S_IDLE;
            w_cnt <= '0;
            n_reg <= '0;
            t     <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                w_cnt <= '0;
                t     <= '0;
                n_reg <= accept ? NUM_VECTORS : '0;
            end
            if (state == S_LOAD && go)
                w_cnt <= w_cnt + RW'(1);
            if (streaming && go)
                t <= t + TW'(1);
        end
    end
endmodule
